// File: rtl/fetch_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit_if : imem request/response and decode handshake bundle         |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+

`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef PC_SEL_WIDTH
`define PC_SEL_WIDTH 1
`endif

interface fetch_unit_if #(
  parameter int XLEN = 32
) ();
  logic                     imem_req_valid;
  logic                     imem_req_ready;
  logic [XLEN-1:0]          imem_req_addr;
  logic                     imem_rsp_valid;
  logic [`INSTR_WIDTH-1:0]  imem_rsp_data;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [`INSTR_WIDTH-1:0]  instr_decode;
  logic [XLEN-1:0]          instr_pc;
  logic [`PC_SEL_WIDTH-1:0] pc_sel;
  logic [XLEN-1:0]          alu_target;
  logic                     misalign_err;

  // Fetch-unit side
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_decode, instr_pc, misalign_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pc_sel, alu_target
  );

  // Memory / decode side
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_decode, instr_pc, misalign_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pc_sel, alu_target
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : in-order instruction fetch with DEPTH-entry buffer and       |
// |              redirect flush. Optional macro: FETCH_MISALIGN_TRAP_EN       |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+

`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef PC_SEL_WIDTH
`define PC_SEL_WIDTH 1
`endif

module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fetch_unit_if.master bus
);

  localparam int                     c_CNT_W     = $clog2(DEPTH + 1);
  localparam int                     c_PTR_W     = $clog2(DEPTH);
  localparam logic [c_CNT_W:0]       c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);
  localparam logic [`INSTR_WIDTH-1:0] c_NOP      = `INSTR_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
    , ST_HALT = 2'd2
`endif
  } state_t;

  state_t                  r_state;
  logic [XLEN-1:0]         r_fetch_pc;
  logic [XLEN-1:0]         r_rsp_pc;
  logic [c_CNT_W-1:0]      r_outstanding;
  logic [c_CNT_W-1:0]      r_discard;
  logic [c_CNT_W-1:0]      r_count;
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [`INSTR_WIDTH-1:0] r_mem_data [DEPTH];
  logic [XLEN-1:0]         r_mem_pc   [DEPTH];

  logic              w_valid;
  logic              w_fire;
  logic              w_redirect;
  logic [c_CNT_W:0]  w_inflight;
  logic              w_credit;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_rsp;
  logic              w_drop;
  logic              w_push;
  logic              w_full;
  logic [XLEN-1:0]   w_target;

  assign w_valid    = (r_count != '0);
  assign w_fire     = w_valid && bus.instr_ready;
  assign w_redirect = w_fire && (bus.pc_sel == `PC_SEL_WIDTH'(1));
  // Credit counts stale in-flight requests too, so the buffer can never overflow.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_credit   = (w_inflight < c_DEPTH_EXT);
  assign w_req_valid = (r_state == ST_RUN) && w_credit && !w_redirect;
  assign w_req_fire = w_req_valid && bus.imem_req_ready;
  assign w_rsp      = bus.imem_rsp_valid && (r_outstanding != '0);
  assign w_drop     = (r_state != ST_RUN) || (r_discard != '0) || w_redirect;
  assign w_push     = w_rsp && !w_drop;
  assign w_full     = (r_count == c_CNT_W'(DEPTH));
  assign w_target   = {bus.alu_target[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_trap;
  assign w_trap           = w_redirect && (bus.alu_target[1:0] != 2'b00);
  assign bus.misalign_err = r_misalign;
`else
  logic w_unused_low_bits;
  assign w_unused_low_bits = ^bus.alu_target[1:0];
  assign bus.misalign_err  = 1'b0;
`endif

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.instr_valid    = w_valid;
  assign bus.instr_decode   = w_valid ? r_mem_data[r_rd_ptr] : c_NOP;
  // When empty, instr_pc shows the PC the next arriving word will carry.
  assign bus.instr_pc       = w_valid ? r_mem_pc[r_rd_ptr] : r_rsp_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (w_trap) begin
            r_state    <= ST_HALT;
            r_misalign <= 1'b1;
          end
`endif
        end
        default: r_state <= r_state;
      endcase

      r_outstanding <= r_outstanding + c_CNT_W'(w_req_fire) - c_CNT_W'(w_rsp);

      if (w_redirect) begin
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
        r_discard  <= r_outstanding - c_CNT_W'(w_rsp);
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_req_fire) begin
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
        if (w_rsp && (r_discard != '0)) begin
          r_discard <= r_discard - c_CNT_W'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
          r_rsp_pc <= r_rsp_pc + XLEN'(4);
        end
        if (w_fire) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end
        r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_fire);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= bus.imem_rsp_data;
      r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Randomized bench for fetch_unit: program-order model of fetch addresses and
// delivered instructions, with a latency-randomized in-order memory.

`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef PC_SEL_WIDTH
`define PC_SEL_WIDTH 1
`endif

module tb_fetch_unit;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        memq[$];
  int          last_due  = 0;
  int          cyc       = 0;
  int          n_total   = 0;
  int          n_bad     = 0;
  int          n_acc     = 0;
  logic [31:0] exp_pc, exp_req;
  bit          exp_mis   = 1'b0;
  bit          hold_prev = 1'b0;
  logic [31:0] prev_dec, prev_pc;

  int          lat_min = 1, lat_max = 1;
  int          ready_pct = 100, redir_pct = 0, req_pct = 100;
  bit          force_redir = 1'b0;
  logic [31:0] force_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_ready    = 1'b0;
    bus.pc_sel         = '0;
    bus.alu_target     = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    memq.delete();
    @(posedge clk); #1; cyc++;
    chk("rst_req_valid",   bus.imem_req_valid, 0);
    chk("rst_req_addr",    bus.imem_req_addr,  RESET_PC);
    chk("rst_instr_valid", bus.instr_valid,    0);
    chk("rst_decode_nop",  bus.instr_decode,   NOP);
    chk("rst_instr_pc",    bus.instr_pc,       RESET_PC);
    chk("rst_misalign",    bus.misalign_err,   0);
    rst = 1'b0;
    last_due  = cyc;
    exp_pc    = RESET_PC;
    exp_req   = RESET_PC;
    exp_mis   = 1'b0;
    hold_prev = 1'b0;
    n_acc     = 0;
    @(posedge clk); #1; cyc++;
    chk("boot_then_req_valid", bus.imem_req_valid, 1);
    chk("boot_then_req_addr",  bus.imem_req_addr,  RESET_PC);
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+2, then advance.
  task automatic step();
    logic [31:0] tgt;
    logic [31:0] aligned;
    bit          fire, redirect, rspv;
    int          lat, due;
    rsp_t        e;

    tgt = $urandom & 32'h0000_0FFF;
    if ($urandom_range(9) == 0) tgt = tgt | 32'hFFFF_F000;
`ifdef FETCH_MISALIGN_TRAP_EN
    tgt[1:0] = 2'b00;
`endif
    bus.instr_ready    = ($urandom_range(99) < ready_pct);
    bus.pc_sel         = `PC_SEL_WIDTH'($urandom_range(99) < redir_pct);
    bus.alu_target     = tgt;
    bus.imem_req_ready = ($urandom_range(99) < req_pct);
    if (force_redir) begin
      bus.instr_ready = 1'b1;
      bus.pc_sel      = `PC_SEL_WIDTH'(1);
      bus.alu_target  = force_tgt;
      force_redir     = 1'b0;
    end
    rspv = 1'b0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      rspv = 1'b1;
      bus.imem_rsp_data = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      bus.imem_rsp_data = $urandom;
    end
    bus.imem_rsp_valid = rspv;
    #1;

    chk("misalign_err", bus.misalign_err, exp_mis);
    chk("inflight_le_depth", ((memq.size() + int'(rspv)) <= DEPTH), 1);
    if (exp_mis) begin
      chk("halt_no_req",   bus.imem_req_valid, 0);
      chk("halt_no_instr", bus.instr_valid,    0);
    end
    if (!bus.instr_valid) chk("nop_when_empty", bus.instr_decode, NOP);
    if (hold_prev) begin
      chk("hold_valid",  bus.instr_valid,  1);
      chk("hold_decode", bus.instr_decode, prev_dec);
      chk("hold_pc",     bus.instr_pc,     prev_pc);
    end

    fire     = bus.instr_valid && bus.instr_ready;
    redirect = fire && (bus.pc_sel == `PC_SEL_WIDTH'(1));
    aligned  = {bus.alu_target[31:2], 2'b00};
    if (fire) begin
      chk("instr_pc",     bus.instr_pc,     exp_pc);
      chk("instr_decode", bus.instr_decode, mem_word(exp_pc));
      exp_pc = redirect ? aligned : exp_pc + 32'd4;
    end
    if (redirect) chk("no_req_on_redirect", bus.imem_req_valid, 0);
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      chk("req_addr", bus.imem_req_addr, exp_req);
      exp_req = exp_req + 32'd4;
      n_acc++;
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      e.addr = bus.imem_req_addr;
      e.due  = due;
      memq.push_back(e);
    end
    if (redirect) begin
      exp_req = aligned;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (bus.alu_target[1:0] != 2'b00) exp_mis = 1'b1;
`endif
    end
    hold_prev = bus.instr_valid && !bus.instr_ready;
    prev_dec  = bus.instr_decode;
    prev_pc   = bus.instr_pc;

    @(posedge clk); #1; cyc++;
  endtask

  initial begin
    int k;
    #1;
    // Streaming with a 1-cycle memory
    do_reset();
    for (int i = 0; i < 40; i++) step();

    // Decode stall: only DEPTH requests may be taken, head holds
    do_reset();
    ready_pct = 0;
    for (int i = 0; i < 12; i++) step();
    chk("stall_req_count",   n_acc,              DEPTH);
    chk("stall_req_blocked", bus.imem_req_valid, 0);
    chk("stall_head_valid",  bus.instr_valid,    1);
    chk("stall_head_pc",     bus.instr_pc,       RESET_PC);
    ready_pct = 100;
    for (int i = 0; i < 20; i++) step();

    // Redirect from 0x4 to 0x100 with 3-cycle memory
    do_reset();
    lat_min = 3; lat_max = 3;
    k = 0;
    while (!(bus.instr_valid && bus.instr_pc == 32'h4) && k < 60) begin step(); k++; end
    chk("t3_reached_pc4", bus.instr_pc, 32'h4);
    force_tgt = 32'h100; force_redir = 1'b1;
    step();
    k = 0;
    while (!bus.instr_valid && k < 60) begin step(); k++; end
    chk("t3_target_pc", bus.instr_pc, 32'h100);
    for (int i = 0; i < 10; i++) step();

    // Misaligned redirect target
    k = 0;
    while (!bus.instr_valid && k < 60) begin step(); k++; end
    force_tgt = 32'h102; force_redir = 1'b1;
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 12; i++) step();
    chk("trap_sticky", bus.misalign_err, 1);
`else
    k = 0;
    while (!bus.instr_valid && k < 60) begin step(); k++; end
    chk("misalign_forced_pc", bus.instr_pc, 32'h100);
`endif

    // Reset with a full buffer
    do_reset();
    lat_min = 1; lat_max = 2;
    ready_pct = 0;
    for (int i = 0; i < 10; i++) step();
    chk("pre_rst_full", bus.instr_valid, 1);
    do_reset();

    // Randomized mixes of latency, backpressure and redirects
    for (int cfg = 0; cfg < 6; cfg++) begin
      do_reset();
      lat_min   = 1;
      lat_max   = 1 + (cfg % 4);
      ready_pct = (cfg < 2) ? 100 : ((cfg < 4) ? 50 : 25);
      redir_pct = (cfg % 3) * 12;
      req_pct   = (cfg % 2) ? 70 : 100;
      for (int i = 0; i < 300; i++) step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that supplies `instr_decode` to the control decoder and consumes its `pc_sel` redirect decision.
- Owns the fetch PC, issues in-order requests to instruction memory, and buffers returned words in a DEPTH-entry FIFO.
- Presents one instruction per cycle to decode through a valid/ready handshake.
- Flushes the FIFO and discards stale in-flight responses on a taken branch or jump.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, FIFO entries and maximum (outstanding + buffered) instructions; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address, word aligned.
- imem_rsp_valid  in  1  response valid; responses are in order, latency ≥1 cycle, no backpressure.
- imem_rsp_data  in  `INSTR_WIDTH  returned instruction.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes head.
- instr_decode  out  `INSTR_WIDTH  head instruction, or NOP 32'h0000_0013 when empty.
- instr_pc  out  XLEN  PC of head instruction.
- pc_sel  in  `PC_SEL_WIDTH  from control: 0 = PC+4, 1 = ALU target.
- alu_target  in  XLEN  redirect target.
- misalign_err  out  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset (rst high at a clk edge) sets:
  - state=BOOT; fetch_pc=RESET_PC; rsp_pc=RESET_PC.
  - outstanding=0; discard_cnt=0; FIFO empty.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr_decode=NOP, instr_pc=RESET_PC, misalign_err=0.
- Reset mid-operation abandons everything. Responses for pre-reset requests that arrive after reset are not tracked, so the memory model must be reset with the fetch unit.
- FSM states:
  - BOOT: lasts one cycle, no requests; then RUN.
  - RUN: normal operation.
  - HALT: only when the optional feature is enabled.
- Request issue in RUN:
  - imem_req_valid = (outstanding + fifo_count < DEPTH) && !redirect.
  - imem_req_addr = fetch_pc.
  - On req_valid && req_ready: fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding increments.
- Consume: fire = instr_valid && instr_ready pops the head.
- Redirect condition: redirect = fire && pc_sel==1.
- Response handling:
  - On rsp_valid, outstanding decrements.
  - If discard_cnt>0 (or redirect this cycle): the response is dropped and discard_cnt decrements (when >0).
  - Otherwise {rsp_pc, data} is pushed and rsp_pc += 4.
- Redirect cycle effects:
  - No request is issued.
  - FIFO is flushed; a same-cycle push is dropped.
  - fetch_pc <= target; rsp_pc <= target.
  - discard_cnt <= outstanding − rsp_valid.
  - Target = {alu_target[XLEN-1:2], 2'b00}.
- Simultaneous push and pop: both occur, so count is unchanged.
- Push on empty FIFO: instr_valid rises the next cycle (FIFO is registered, no bypass). Minimum latency is req accept → rsp (L cycles) → instr_valid one cycle later.
- Full: the credit rule guarantees the FIFO never overflows. A push while full is a design error and must be flagged by an assertion.
- outstanding and discard_cnt are $clog2(DEPTH+1) bits wide.
- While instr_valid=1 and instr_ready=0, instr_decode and instr_pc hold stable.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined, on redirect with alu_target[1:0]!=0:
  - Flush as normal, enter HALT.
  - misalign_err=1, sticky until rst.
  - In HALT, no requests issue, all responses are dropped, instr_valid=0.
- Undefined:
  - Low target bits are forced to 00; no HALT state.
  - misalign_err is constant 0.

Test Plan:
1. Reset, 1-cycle memory, instr_ready=1 → addresses 0x0,0x4,0x8… issued; instr_pc 0x0,0x4,0x8… in order; no gaps after fill.
2. instr_ready=0 for 10 cycles → outstanding+fifo_count never exceeds 2; imem_req_valid=0 once full; head 0x0 stable; streaming resumes in order when released.
3. Memory latency 3 with 2 in flight, decode consumes 0x4 with pc_sel=1, alu_target=0x100 → both stale responses dropped; next instr_pc=0x100, then 0x104.
4. Redirect in the same cycle a response arrives → that response is dropped; discard_cnt=outstanding−1; first delivered instruction has instr_pc=target.
5. Redirect with alu_target=0x102: without the macro → next fetch 0x100. With FETCH_MISALIGN_TRAP_EN → misalign_err=1, no further requests, instr_valid=0 until rst.
6. rst asserted mid-stream with a full FIFO → next cycle instr_valid=0, instr_decode=0x00000013, fetching restarts at RESET_PC after one BOOT cycle.
